// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Operation phases: load operands, shift one bit per clock, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SERIAL_ADDER_W_DEFAULT = 8;

    // Carry generation of a 1-bit full adder: true when two or more inputs are set.
    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, the additive companion of the full-subtractor cell.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module full_adder
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs, carry is their majority.
    always_comb begin
        s  = a ^ b ^ ci;
        co = majority3(a, b, ci);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: LSB-first through one full adder; signed overflow flag with SERIAL_ADDER_OVF_EN.
// Latency: W cycles from accept edge to out_valid; minimum initiation interval W+2 cycles.
// Backpressure: out_ready low holds the result indefinitely; in_ready is low from accept until the result is taken.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int W = SERIAL_ADDER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic         cout,
    output logic         ovf
`else
    output logic         cout
`endif
);

    // cnt indexes the bit being added; $clog2(W) bits is enough since it stops at W-1.
    localparam int              CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               run_last;
    logic               in_ready_q;

    logic [W-1:0]       a_sr;
    logic [W-1:0]       b_sr;
    logic [W-1:0]       sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_s;
    logic               fa_co;

    // The one adder cell: consumes the current LSBs and the running carry.
    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the accept / last-bit strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        run_last  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    run_last  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // in_ready is registered so it is low throughout reset and rises the cycle after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt == IDLE);
        end
    end

    // Operand load on accept, then one shift/add step per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[W-1:1]};
            carry  <= fa_co;
            // Hold at the last index rather than wrapping back to zero.
            if (!run_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (run_last) begin
            ovf_q <= carry ^ fa_co;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state == DONE);
    assign sum       = sum_sr;
    assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at W=8 and W=2 against an arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises held results with out_ready low.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       iv8, ir8, ov8, or8, ci8, co8;
    logic [7:0] a8, b8, s8;
    logic       iv2, ir2, ov2, or2, ci2, co2;
    logic [1:0] a2, b2, s2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int tests = 0;
    int fails = 0;

    serial_adder #(.W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .cin       (ci8),
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (s8),
`ifdef SERIAL_ADDER_OVF_EN
        .cout      (co8),
        .ovf       (ovf8)
`else
        .cout      (co8)
`endif
    );

    serial_adder #(.W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .a         (a2),
        .b         (b2),
        .cin       (ci2),
        .out_valid (ov2),
        .out_ready (or2),
        .sum       (s2),
`ifdef SERIAL_ADDER_OVF_EN
        .cout      (co2),
        .ovf       (ovf2)
`else
        .cout      (co2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ir(input int s);
        return (s != 0) ? ir2 : ir8;
    endfunction

    function automatic logic get_ov(input int s);
        return (s != 0) ? ov2 : ov8;
    endfunction

    function automatic logic get_co(input int s);
        return (s != 0) ? co2 : co8;
    endfunction

    function automatic logic [7:0] get_sum(input int s);
        return (s != 0) ? {6'd0, s2} : s8;
    endfunction

`ifdef SERIAL_ADDER_OVF_EN
    function automatic logic get_ovf(input int s);
        return (s != 0) ? ovf2 : ovf8;
    endfunction
`endif

    task automatic drive_in(input int s, input logic v, input logic [7:0] av, input logic [7:0] bv, input logic ci);
        if (s != 0) begin
            iv2 = v; a2 = av[1:0]; b2 = bv[1:0]; ci2 = ci;
        end else begin
            iv8 = v; a8 = av; b8 = bv; ci8 = ci;
        end
    endtask

    task automatic set_out_ready(input int s, input logic v);
        if (s != 0) or2 = v;
        else        or8 = v;
    endtask

    // Reference: plain integer addition, truncated to W bits, plus signed range test.
    task automatic model(input int s, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         output logic [7:0] es, output logic ec, output logic eo);
        int w, mask, ua, ub, full, sa, sb, ss;
        w    = (s != 0) ? 2 : 8;
        mask = (1 << w) - 1;
        ua   = int'(av) & mask;
        ub   = int'(bv) & mask;
        full = ua + ub + int'(ci);
        es   = 8'(full & mask);
        ec   = ((full >> w) & 1) != 0;
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        ss   = sa + sb + int'(ci);
        eo   = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    endtask

    // Present operands once in_ready is seen, hold for one edge; returns at the negedge after accept.
    task automatic start_op(input int s, input logic [7:0] av, input logic [7:0] bv, input logic ci);
        int n;
        n = 0;
        while (get_ir(s) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 32'(get_ir(s)), 32'd1);
        drive_in(s, 1'b1, av, bv, ci);
        @(posedge clk);
        @(negedge clk);
        drive_in(s, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    // Count edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(input int s, output int n);
        n = 0;
        while (get_ov(s) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input int s, input string tag, input logic [7:0] es, input logic ec, input logic eo);
        check({tag, "_sum"},  32'(get_sum(s)), 32'(es));
        check({tag, "_cout"}, 32'(get_co(s)),  32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"},  32'(get_ovf(s)), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in overflow model");
`endif
    endtask

    task automatic do_op(input int s, input string tag, input logic [7:0] av, input logic [7:0] bv, input logic ci);
        logic [7:0] es;
        logic       ec, eo;
        int         n;
        model(s, av, bv, ci, es, ec, eo);
        start_op(s, av, bv, ci);
        wait_result(s, n);
        check({tag, "_latency"}, 32'(n), (s != 0) ? 32'd2 : 32'd8);
        check_result(s, tag, es, ec, eo);
        check({tag, "_ready_in_done"}, 32'(get_ir(s)), 32'd0);
        set_out_ready(s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_out_ready(s, 1'b0);
        check({tag, "_valid_drop"}, 32'(get_ov(s)), 32'd0);
        check({tag, "_ready_after"}, 32'(get_ir(s)), 32'd1);
    endtask

    initial begin
        logic [7:0] es;
        logic       ec, eo;
        int         n;

        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b0;
        iv2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; or2 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_in_ready8",  32'(ir8), 32'd0);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        check("rst_sum8",       32'(s8),  32'd0);
        check("rst_cout8",      32'(co8), 32'd0);
        check("rst_in_ready2",  32'(ir2), 32'd0);
        check("rst_out_valid2", 32'(ov2), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready8", 32'(ir8), 32'd1);
        check("post_rst_ready2", 32'(ir2), 32'd1);

        // Directed cases.
        do_op(0, "add_05_03", 8'h05, 8'h03, 1'b0);
        do_op(0, "add_ff_01", 8'hFF, 8'h01, 1'b0);
        do_op(0, "add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        do_op(0, "add_7f_01", 8'h7F, 8'h01, 1'b0);
        do_op(0, "add_80_80", 8'h80, 8'h80, 1'b0);

        // Back-pressure: result held five cycles, an in_valid pulse is ignored.
        model(0, 8'h3C, 8'h5A, 1'b1, es, ec, eo);
        start_op(0, 8'h3C, 8'h5A, 1'b1);
        wait_result(0, n);
        check("bp_latency", 32'(n), 32'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(ov8), 32'd1);
            check("bp_ready_low",  32'(ir8), 32'd0);
            check_result(0, "bp_hold", es, ec, eo);
            drive_in(0, (i == 2), 8'h11, 8'h00, 1'b0);
            @(negedge clk);
        end
        drive_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        check_result(0, "bp_final", es, ec, eo);
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or8 = 1'b0;
        check("bp_transfer_once", 32'(ov8), 32'd0);
        check("bp_ready_after",   32'(ir8), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("bp_no_ghost_op", 32'(ov8), 32'd0);
        end

        // Reset during the third RUN cycle.
        start_op(0, 8'h5A, 8'h33, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_in_ready",  32'(ir8), 32'd0);
            check("mid_rst_out_valid", 32'(ov8), 32'd0);
            check("mid_rst_sum",       32'(s8),  32'd0);
            check("mid_rst_cout",      32'(co8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check("mid_rst_ovf",       32'(ovf8), 32'd0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(ir8), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("mid_rst_no_result", 32'(ov8), 32'd0);
        end
        do_op(0, "add_10_20", 8'h10, 8'h20, 1'b0);

        // Randomized W=8 operations.
        for (int i = 0; i < 30; i++) begin
            do_op(0, "rand8", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Exhaustive W=2.
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    do_op(1, "exh2", 8'(av), 8'(bv), 1'(c));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
